// File: rtl/timer_sched_pkg.sv
// Shared types and sizing helpers for the shared delay-timer scheduler.
package timer_sched_pkg;

   localparam int NREQ_DEF = 3;
   localparam int CW_DEF   = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Index width; never below one bit so a 1-wide id port stays legal.
   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int IDW = id_width(NREQ_DEF);

endpackage

// File: rtl/timer_sched_rr_arbiter.sv
// Combinational round-robin arbiter: the first set request strictly after
// 'last' (wrapping) wins.
module rr_arbiter
   import timer_sched_pkg::*;
#(
   parameter int  NREQ = NREQ_DEF,
   localparam int IW   = id_width(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   last,
   output logic [NREQ-1:0] gnt,
   output logic [IW-1:0]   gnt_id,
   output logic            any
);

   logic [2*NREQ-1:0] dbl;
   logic [2*NREQ-1:0] rot;
   int                sh;
   int                idx;

   always_comb begin
      dbl    = {req, req};
      sh     = int'(last) + 1;
      rot    = dbl >> sh;
      gnt    = '0;
      gnt_id = '0;
      any    = 1'b0;
      idx    = 0;
      // Bit i of the rotated vector is requester (last+1+i) mod NREQ.
      for (int i = 0; i < NREQ; i++) begin
         if (!any && rot[i]) begin
            any = 1'b1;
            idx = sh + i;
            if (idx >= NREQ) idx = idx - NREQ;
            gnt_id = IW'(idx);
            gnt    = NREQ'(1) << idx;
         end
      end
   end

endmodule

// File: rtl/timer_sched.sv
// One down-counting delay timer shared round-robin among NREQ requesters;
// the owner receives a one-cycle done pulse when its delay expires.
module timer_sched
   import timer_sched_pkg::*;
#(
   parameter int  NREQ = NREQ_DEF,
   parameter int  CW   = CW_DEF,
   localparam int IW   = id_width(NREQ)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NREQ-1:0]  req,
   input  logic [NREQ*CW-1:0] delay,
   output logic [NREQ-1:0]  grant,
   output logic [NREQ-1:0]  done,
   output logic             busy,
   output logic [IW-1:0]    cur_id
);

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [IW-1:0]   cur_id_q, cur_id_d;
   logic [IW-1:0]   last_q, last_d;
   logic [NREQ-1:0] grant_q, grant_d;
   logic [NREQ-1:0] done_q, done_d;

   logic [NREQ-1:0] arb_gnt;
   logic [IW-1:0]   arb_id;
   logic            arb_any;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .req    (req),
      .last   (last_q),
      .gnt    (arb_gnt),
      .gnt_id (arb_id),
      .any    (arb_any)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      cur_id_d = cur_id_q;
      last_d   = last_q;
      grant_d  = grant_q;
      done_d   = '0;
      case (state_q)
         IDLE: begin
            if (arb_any) begin
               cnt_d    = delay[int'(arb_id)*CW +: CW];
               cur_id_d = arb_id;
               grant_d  = arb_gnt;
               state_d  = COUNT;
            end
         end
         COUNT: begin
            // A dropped owner request cancels silently and yields the timer.
            if (!req[cur_id_q]) begin
               grant_d = '0;
               last_d  = cur_id_q;
               state_d = IDLE;
            end else if (cnt_q == '0) begin
               done_d  = grant_q;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         DONE: begin
            grant_d = '0;
            last_d  = cur_id_q;
            state_d = IDLE;
         end
         default: begin
            grant_d = '0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         cur_id_q <= '0;
         last_q   <= IW'(NREQ - 1);
         grant_q  <= '0;
         done_q   <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         cur_id_q <= cur_id_d;
         last_q   <= last_d;
         grant_q  <= grant_d;
         done_q   <= done_d;
      end
   end

   assign grant  = grant_q;
   assign done   = done_q;
   assign busy   = (state_q != IDLE);
   assign cur_id = cur_id_q;

endmodule

// File: tb/tb_timer_sched.sv
// Directed bench for timer_sched: fixed-latency checks of grant/done timing,
// round-robin order, cancel and asynchronous reset.
module tb_timer_sched;

  localparam int NREQ = 3;
  localparam int CW   = 8;

  logic               clk;
  logic               rst;
  logic [NREQ-1:0]    req;
  logic [NREQ*CW-1:0] delay;
  logic [NREQ-1:0]    grant;
  logic [NREQ-1:0]    done;
  logic               busy;
  logic [1:0]         cur_id;

  int n_chk;
  int n_bad;
  int oh_bad;

  timer_sched #(.NREQ(NREQ), .CW(CW)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .delay  (delay),
    .grant  (grant),
    .done   (done),
    .busy   (busy),
    .cur_id (cur_id)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // grant and done must never have more than one bit set
  always @(negedge clk) begin
    if (!rst && (!$onehot0(grant) || !$onehot0(done))) oh_bad++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tickn(input int n);
    repeat (n) tick();
  endtask

  task automatic set_delay(input int i, input logic [CW-1:0] v);
    delay[i*CW +: CW] = v;
  endtask

  task automatic do_reset();
    req   = '0;
    delay = '0;
    rst   = 1'b1;
    tickn(2);
    rst   = 1'b0;
  endtask

  initial begin
    n_chk  = 0;
    n_bad  = 0;
    oh_bad = 0;
    rst    = 1'b1;
    req    = '0;
    delay  = '0;
    #12;
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_cur_id", 32'(cur_id), 32'h0);

    // 1: single requester, delay 4
    do_reset();
    req = 3'b001;
    set_delay(0, 8'd4);
    tick();                                   // edge k
    check("t1_grant", 32'(grant), 32'h1);
    check("t1_busy", 32'(busy), 32'h1);
    tickn(4);                                 // k+4
    check("t1_no_done_early", 32'(done), 32'h0);
    tick();                                   // k+5
    check("t1_done", 32'(done), 32'h1);
    check("t1_done_grant", 32'(grant), 32'h1);
    req = 3'b000;
    tick();                                   // k+6
    check("t1_done_clr", 32'(done), 32'h0);
    check("t1_busy_low", 32'(busy), 32'h0);
    check("t1_grant_low", 32'(grant), 32'h0);

    // 2: all three held, delays 10/15/20
    do_reset();
    set_delay(0, 8'd10);
    set_delay(1, 8'd15);
    set_delay(2, 8'd20);
    req = 3'b111;
    tick();                                   // k
    check("t2_g0", 32'(grant), 32'h1);
    tickn(11);                                // k+11
    check("t2_d0", 32'(done), 32'h1);
    tick();                                   // k+12
    check("t2_idle0", 32'(grant), 32'h0);
    tick();                                   // k+13
    check("t2_g1", 32'(grant), 32'h2);
    check("t2_id1", 32'(cur_id), 32'h1);
    tickn(16);                                // k+29
    check("t2_d1", 32'(done), 32'h2);
    tickn(2);                                 // k+31
    check("t2_g2", 32'(grant), 32'h4);
    tickn(21);                                // k+52
    check("t2_d2", 32'(done), 32'h4);
    req = 3'b000;
    tickn(2);
    check("t2_end_busy", 32'(busy), 32'h0);

    // 3: fairness, req[2] arrives while req[1] counts
    do_reset();
    set_delay(1, 8'd5);
    set_delay(2, 8'd3);
    req = 3'b010;
    tick();                                   // k
    check("t3_g1", 32'(grant), 32'h2);
    req = 3'b110;
    tickn(6);                                 // k+6
    check("t3_d1", 32'(done), 32'h2);
    tickn(2);                                 // k+8
    check("t3_g2", 32'(grant), 32'h4);
    check("t3_id2", 32'(cur_id), 32'h2);
    tickn(4);                                 // k+12
    check("t3_d2", 32'(done), 32'h4);
    tickn(2);                                 // k+14
    check("t3_g1_again", 32'(grant), 32'h2);
    req = 3'b000;
    tickn(2);

    // 4: delay 0 with single requester re-grant, then delay 255
    do_reset();
    set_delay(0, 8'd0);
    req = 3'b001;
    tick();                                   // k
    check("t4_g0", 32'(grant), 32'h1);
    tick();                                   // k+1
    check("t4_d0", 32'(done), 32'h1);
    tick();                                   // k+2
    check("t4_idle", 32'(busy), 32'h0);
    tick();                                   // k+3
    check("t4_regrant", 32'(grant), 32'h1);
    set_delay(0, 8'd9);                       // ignored: already sampled
    tick();                                   // k+4
    check("t4_d0_again", 32'(done), 32'h1);
    req = 3'b000;
    tick();
    set_delay(0, 8'd255);
    req = 3'b001;
    tick();                                   // k
    check("t4_g255", 32'(grant), 32'h1);
    set_delay(0, 8'd1);                       // ignored: already sampled
    tickn(255);                               // k+255
    check("t4_no_wrap", 32'(done), 32'h0);
    check("t4_busy255", 32'(busy), 32'h1);
    tick();                                   // k+256
    check("t4_d255", 32'(done), 32'h1);
    req = 3'b000;
    tickn(2);

    // 5: owner cancels mid-count, pending requester takes over
    do_reset();
    set_delay(0, 8'd8);
    set_delay(1, 8'd2);
    req = 3'b011;
    tick();                                   // k
    check("t5_g0", 32'(grant), 32'h1);
    tickn(3);                                 // k+3
    req = 3'b010;
    tick();                                   // k+4
    check("t5_cancel_grant", 32'(grant), 32'h0);
    check("t5_cancel_done", 32'(done), 32'h0);
    check("t5_cancel_busy", 32'(busy), 32'h0);
    tick();                                   // k+5
    check("t5_g1", 32'(grant), 32'h2);
    check("t5_no_done0", 32'(done), 32'h0);
    tickn(3);                                 // k+8
    check("t5_d1", 32'(done), 32'h2);
    req = 3'b000;
    tickn(2);

    // 6: async reset while requester 1 counts
    do_reset();
    set_delay(0, 8'd2);
    set_delay(1, 8'd50);
    req = 3'b111;
    tick();                                   // k
    tickn(3);                                 // k+3
    check("t6_d0", 32'(done), 32'h1);
    tickn(2);                                 // k+5
    check("t6_g1", 32'(grant), 32'h2);
    tickn(2);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_grant", 32'(grant), 32'h0);
    check("t6_rst_busy", 32'(busy), 32'h0);
    check("t6_rst_done", 32'(done), 32'h0);
    check("t6_rst_id", 32'(cur_id), 32'h0);
    tick();
    rst = 1'b0;
    tick();
    check("t6_tie_g0", 32'(grant), 32'h1);
    check("t6_tie_id", 32'(cur_id), 32'h0);
    req = 3'b000;
    tickn(2);

    check("onehot_grant_done", 32'(oh_bad), 32'h0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
